// File: rtl/gmii_rx_framer.sv
// Receive framer for one port: strips preamble/SFD from the recovered GMII byte stream,
// delimits frames with sof/eof, checks length and CRC-32 and keeps saturating frame counters.
module gmii_rx_framer #(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           gmii_rxd,
  input  logic                 gmii_rx_dv,
  input  logic                 gmii_rx_er,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic                 out_err,
  output logic [15:0]          out_len,
  output logic [CNT_WIDTH-1:0] good_frames,
  output logic [CNT_WIDTH-1:0] bad_frames
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2,
    S_DROP     = 2'd3
  } state_t;

  localparam logic [15:0]          MIN_LEN     = 16'(MIN_FRAME_LEN);
  localparam logic [15:0]          MAX_LEN     = 16'(MAX_FRAME_LEN);
  localparam logic [31:0]          CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0]          CRC_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0]          CRC_RESIDUE = 32'hC704_DD7B;
  localparam logic [7:0]           PRE_BYTE    = 8'h55;
  localparam logic [7:0]           SFD_BYTE    = 8'hD5;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};

  // Data bits enter LSB first into an MSB-shifting register, which gives the reflected CRC.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  state_t      r_state;
  logic [7:0]  r_rxd;
  logic        r_dv;
  logic        r_er;
  logic        r_dv_prev;
  logic [7:0]  r_hold;
  logic [15:0] r_len;
  logic [31:0] r_crc;
  logic        r_er_sticky;
  logic        w_dv_rise;
  logic        w_frame_bad;

  assign w_dv_rise   = r_dv & ~r_dv_prev;
  assign w_frame_bad = r_er_sticky | (r_len < MIN_LEN) | (r_crc != CRC_RESIDUE);

  // Input sample stage; dv history resets high so a frame in flight at release is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rxd     <= 8'd0;
      r_dv      <= 1'b1;
      r_er      <= 1'b0;
      r_dv_prev <= 1'b1;
    end else begin
      r_rxd     <= gmii_rxd;
      r_dv      <= gmii_rx_dv;
      r_er      <= gmii_rx_er;
      r_dv_prev <= r_dv;
    end
  end

  // Framing FSM with hold register, registered output stage and frame counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_hold      <= 8'd0;
      r_len       <= 16'd0;
      r_crc       <= CRC_INIT;
      r_er_sticky <= 1'b0;
      out_data    <= 8'd0;
      out_valid   <= 1'b0;
      out_sof     <= 1'b0;
      out_eof     <= 1'b0;
      out_err     <= 1'b0;
      out_len     <= 16'd0;
      good_frames <= {CNT_WIDTH{1'b0}};
      bad_frames  <= {CNT_WIDTH{1'b0}};
    end else begin
      out_data  <= 8'd0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_err   <= 1'b0;
      out_len   <= 16'd0;
      case (r_state)
        S_IDLE: begin
          if (w_dv_rise) begin
            if (r_rxd == PRE_BYTE) begin
              r_state <= S_PREAMBLE;
            end else if (r_rxd == SFD_BYTE) begin
              r_state     <= S_DATA;
              r_crc       <= CRC_INIT;
              r_len       <= 16'd0;
              r_er_sticky <= 1'b0;
            end else begin
              r_state    <= S_DROP;
              bad_frames <= sat_inc(bad_frames);
            end
          end
        end
        S_PREAMBLE: begin
          if (!r_dv) begin
            r_state <= S_IDLE;
          end else if (r_er || ((r_rxd != PRE_BYTE) && (r_rxd != SFD_BYTE))) begin
            r_state    <= S_DROP;
            bad_frames <= sat_inc(bad_frames);
          end else if (r_rxd == SFD_BYTE) begin
            r_state     <= S_DATA;
            r_crc       <= CRC_INIT;
            r_len       <= 16'd0;
            r_er_sticky <= 1'b0;
          end
        end
        S_DATA: begin
          if (!r_dv) begin
            r_state <= S_IDLE;
            if (r_len == 16'd0) begin
              bad_frames <= sat_inc(bad_frames);
            end else begin
              out_valid <= 1'b1;
              out_data  <= r_hold;
              out_sof   <= (r_len == 16'd1);
              out_eof   <= 1'b1;
              out_err   <= w_frame_bad;
              out_len   <= r_len;
              if (w_frame_bad) bad_frames  <= sat_inc(bad_frames);
              else             good_frames <= sat_inc(good_frames);
            end
          end else if (r_len == MAX_LEN) begin
            // Byte MAX+1 arrived: close the frame on the held byte and discard the rest.
            r_state    <= S_DROP;
            out_valid  <= 1'b1;
            out_data   <= r_hold;
            out_sof    <= (r_len == 16'd1);
            out_eof    <= 1'b1;
            out_err    <= 1'b1;
            out_len    <= MAX_LEN;
            bad_frames <= sat_inc(bad_frames);
          end else begin
            r_crc       <= crc32_byte(r_crc, r_rxd);
            r_len       <= (r_len == 16'hFFFF) ? r_len : r_len + 16'd1;
            r_hold      <= r_rxd;
            r_er_sticky <= r_er_sticky | r_er;
            if (r_len != 16'd0) begin
              out_valid <= 1'b1;
              out_data  <= r_hold;
              out_sof   <= (r_len == 16'd1);
            end
          end
        end
        S_DROP: begin
          if (!r_dv) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/gmii_rx_framer.md
Name: gmii_rx_framer

Overview:
Receive-side framer between the RGMII input stage (DDR already recovered to an 8-bit SDR GMII byte stream) and the MAC rx queue of each port.
- Strips preamble and SFD.
- Delimits each frame with sof/eof.
- Checks length and CRC-32, and reports a per-frame error flag plus saturating good/bad frame counters.
- One instance per port, clocked by that port's rx clock.

Parameters:
MIN_FRAME_LEN, 64, minimum legal frame length in bytes (DA through FCS inclusive)
MAX_FRAME_LEN, 1518, maximum legal length; longer frames are truncated
CNT_WIDTH, 32, width of the statistics counters

Ports:
clk  in  1  port rx clock; single clock domain
reset  in  1  asynchronous, active-high reset
gmii_rxd  in  8  received byte
gmii_rx_dv  in  1  data valid
gmii_rx_er  in  1  receive error
out_data  out  8  frame byte (DA through FCS; FCS passed through)
out_valid  out  1  out_data valid this cycle
out_sof  out  1  first byte of frame; qualified by out_valid
out_eof  out  1  last byte of frame; qualified by out_valid
out_err  out  1  frame bad; valid only with out_eof
out_len  out  16  frame byte count; valid only with out_eof
good_frames  out  CNT_WIDTH  saturating count of good frames
bad_frames  out  CNT_WIDTH  saturating count of bad and dropped frames

Behaviour:
- Reset:
  - All outputs are 0 and the FSM is in IDLE.
  - dv_prev resets to 1, so a frame already in progress at reset release is ignored until dv is seen low.
- The output stage is registered.
- Latency: the byte sampled at cycle N appears on out_data at cycle N+2. The 1-byte hold register lets eof coincide with the last byte.
- No backpressure. The downstream block accepts one byte per cycle.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
  - IDLE:
    - A frame starts only on dv rising (dv=1, dv_prev=0).
    - 0x55 -> PREAMBLE.
    - 0xD5 -> DATA (no preamble is legal).
    - Any other byte -> DROP, and bad_frames increments.
  - PREAMBLE:
    - 0x55 -> stay.
    - 0xD5 -> DATA.
    - Any other byte, or rx_er=1 -> DROP, and bad_frames increments.
    - dv=0 -> IDLE with no count (false carrier).
  - DATA, per byte with dv=1:
    - Update CRC, increment the length counter, and place the byte in the hold register.
    - The previously held byte is emitted; the first emitted byte carries sof.
    - rx_er=1 sets a sticky err flag.
  - DATA, dv falls:
    - The held byte is emitted with eof.
    - out_len = byte count.
    - out_err = er_sticky OR len<MIN_FRAME_LEN OR CRC residue != 0xC704DD7B.
    - Then IDLE.
  - DATA, count reaches MAX_FRAME_LEN with dv still high on the next byte:
    - Emit byte MAX_FRAME_LEN with eof and err=1, out_len=MAX_FRAME_LEN.
    - Go to DROP.
    - A frame of exactly MAX_FRAME_LEN whose dv falls normally is not truncated.
  - DATA, dv falls with zero data bytes after SFD: nothing is emitted, bad_frames increments, then IDLE.
  - DROP: discard all bytes until dv=0, then IDLE.
- CRC:
  - Standard Ethernet CRC-32: reflected, polynomial 0x04C11DB7.
  - Initialised to 0xFFFFFFFF on SFD.
  - Covers all bytes after SFD including FCS.
  - Good when the residue equals 0xC704DD7B.
- Counters:
  - Exactly one of good_frames / bad_frames increments per started frame, in the cycle eof is emitted or at the drop decision.
  - Both counters saturate at all-ones.
- Back-to-back frames:
  - A single dv-low cycle between frames is sufficient.
  - The eof of frame K and the bytes of frame K+1 never overlap on the output.
- Length counter is 16 bits and saturates. Truncation guarantees it never exceeds MAX_FRAME_LEN on output.
- Reset asserted mid-frame: outputs clear immediately and no eof is emitted for the partial frame. After release, remaining bytes are ignored until dv has been low.

Test Plan:
1. 7x0x55, 0xD5, then 64-byte frame with correct FCS. Expect:
   - sof with byte 1 at SFD-cycle+3 and 64 valid cycles.
   - eof on byte 64 with err=0, len=64.
   - good_frames=1.
2. Same frame with one payload bit flipped -> eof with err=1, len=64; bad_frames=1, good_frames unchanged.
3. 60-byte frame with valid CRC -> eof err=1, len=60. Separately, rx_er pulsed on byte 20 of a good 100-byte frame -> err=1, len=100.
4. 1600-byte frame -> eof err=1 on byte 1518, len=1518; no output for bytes 1519-1600; bad_frames +1. A 1518-byte good frame -> err=0.
5. Two good 64-byte frames separated by one dv-low cycle -> two complete sof..eof sequences, no overlap, good_frames=2. Preamble byte 0x57 -> no output, bad_frames +1.
6. Reset asserted at byte 30 of a 200-byte frame, released at byte 40, dv high throughout -> all outputs 0 during reset, no output for that frame, counters 0. The next frame after a dv-low gap is received normally.
